// File: rtl/truth_table_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer_pkg
// Shared definitions for the truth-table sequencer:
//   state_t  - sweep controller state encoding
//   table_w  - width of the packed result table (2 bits per row, 2**n_in rows)
// -----------------------------------------------------------------------------
package truth_table_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic int table_w(input int n_in);
    return 2 * (2 ** n_in);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Conditions one raw pushbutton: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on each rising edge of the debounced level.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   btn_raw_i  raw asynchronous button level
//   pulse_o    1-cycle pulse, 2 + DEBOUNCE_CYCLES + 1 cycles after a clean press
// -----------------------------------------------------------------------------
module button_debounce
  import truth_table_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_seen_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; any agreeing cycle restarts the count from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      cnt_q        <= '0;
      level_seen_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_seen_q <= level_q;
      pulse_q      <= level_q & ~level_seen_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
// Steps a combinational block under test through all 2**N_IN input vectors and
// captures its two outputs per row into a packed result table. Rows advance on
// a debounced step button (manual) or after AUTO_PERIOD cycles (auto).
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   btn_run    raw button: start / restart a sweep
//   btn_step   raw button: advance one row in manual mode
//   mode_auto  1 = auto-run, 0 = manual step
//   y_in       {Y2,Y1} from the block under test
//   stim       current input vector to the block under test (MSB = A)
//   busy       sweep in progress
//   done       full table captured
//   result     row k at [2k+1:2k] = {Y2,Y1}
// -----------------------------------------------------------------------------
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN            = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_CYCLES   = 4,
  parameter int AUTO_PERIOD     = 12000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_run,
  input  logic                        btn_step,
  input  logic                        mode_auto,
  input  logic [1:0]                  y_in,
  output logic [N_IN-1:0]             stim,
  output logic                        busy,
  output logic                        done,
  output logic [table_w(N_IN)-1:0]    result
);

  localparam int TW  = table_w(N_IN);
  localparam int SCW = $clog2(SETTLE_CYCLES) + 1;
  localparam int PCW = $clog2(AUTO_PERIOD) + 1;

  localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SCW-1:0]  SETTLE_ONE  = SCW'(1);
  localparam logic [PCW-1:0]  PERIOD_LAST = PCW'(AUTO_PERIOD - 1);
  localparam logic [PCW-1:0]  PERIOD_ONE  = PCW'(1);

  logic run_p;
  logic step_p;

  state_t          state_q,  state_d;
  logic [N_IN-1:0] idx_q,    idx_d;
  logic [TW-1:0]   result_q, result_d;
  logic [SCW-1:0]  settle_q, settle_d;
  logic [PCW-1:0]  period_q, period_d;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk       (clk),
    .reset     (reset),
    .btn_raw_i (btn_run),
    .pulse_o   (run_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk       (clk),
    .reset     (reset),
    .btn_raw_i (btn_step),
    .pulse_o   (step_p)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    settle_d = settle_q;
    period_d = period_q;

    // run_p restarts from any state and outranks a simultaneous step_p.
    if (run_p) begin
      state_d  = ST_DRIVE;
      idx_d    = '0;
      result_d = '0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_SAMPLE;
          end else begin
            settle_d = settle_q + SETTLE_ONE;
          end
        end
        ST_SAMPLE: begin
          result_d[{idx_q, 1'b0} +: 2] = y_in;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_STEP;
            period_d = '0;
          end
        end
        ST_STEP: begin
          // mode_auto is re-evaluated every cycle; the period counter
          // saturates so a late switch to auto advances immediately.
          if ((mode_auto && (period_q >= PERIOD_LAST)) || (!mode_auto && step_p)) begin
            state_d  = ST_DRIVE;
            idx_d    = idx_q + IDX_ONE;
            settle_d = '0;
          end else if (period_q < PERIOD_LAST) begin
            period_d = period_q + PERIOD_ONE;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      result_q <= '0;
      settle_q <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      settle_q <= settle_d;
      period_q <= period_d;
    end
  end

  // idx only changes on entry to DRIVE (or restart), so it doubles as the
  // held stimulus through SAMPLE, STEP and DONE.
  assign stim   = idx_q;
  assign busy   = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE) || (state_q == ST_STEP);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

  logic        clk;
  logic        reset;
  logic        btn_run;
  logic        btn_step;
  logic        mode_auto;
  logic [1:0]  y_in;
  logic [2:0]  stim;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int vectors;
  int miscompares;
  int run_hold;
  int step_hold;

  localparam logic [15:0] TABLE_EXP = 16'hC228;

  truth_table_sequencer #(
    .N_IN            (3),
    .DEBOUNCE_CYCLES (4),
    .SETTLE_CYCLES   (2),
    .AUTO_PERIOD     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .mode_auto (mode_auto),
    .y_in      (y_in),
    .stim      (stim),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // Block under test: Y2 = odd parity, Y1 = AND of all inputs.
  assign y_in = {^stim, &stim};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    btn_run  = (run_hold > 0);
    if (run_hold > 0) run_hold--;
    btn_step = (step_hold > 0);
    if (step_hold > 0) step_hold--;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    run_hold  = 0;
    step_hold = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode_auto = 1'b0;
    wait_ticks(3);
    vectors++;
    if (stim !== 3'd0) begin miscompares++; $display("FAIL reset_stim: got %0d expected 0", stim); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
    vectors++;
    if (result !== 16'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
    reset = 1'b0;
    wait_ticks(2);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_auto_sweep();
    bit started = 0;
    bit got_done = 0;
    int prev = 0;
    int last = 0;
    do_reset();
    mode_auto = 1'b1;
    run_hold = 8;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (!started) begin
        if (busy) begin
          started = 1;
          last = cyc;
          prev = int'(stim);
          vectors++;
          if (stim !== 3'd0) begin miscompares++; $display("FAIL auto_first_row: got %0d expected 0", stim); end
        end
      end else begin
        if (done) begin got_done = 1; break; end
        if (int'(stim) != prev) begin
          vectors++;
          if (int'(stim) !== prev + 1) begin miscompares++; $display("FAIL auto_row_order: got %0d expected %0d", stim, prev + 1); end
          vectors++;
          if (cyc - last !== 6) begin miscompares++; $display("FAIL auto_row_period: got %0d expected 6", cyc - last); end
          prev = int'(stim);
          last = cyc;
        end
      end
    end
    vectors++;
    if (!got_done) begin miscompares++; $display("FAIL auto_done_timeout: got done=%b expected 1", done); end
    vectors++;
    if (result !== TABLE_EXP) begin miscompares++; $display("FAIL auto_result: got %h expected %h", result, TABLE_EXP); end
    vectors++;
    if (busy !== 1'b0 || stim !== 3'd7) begin miscompares++; $display("FAIL auto_end_state: got busy=%b stim=%0d expected 0 7", busy, stim); end
    $display("test_auto_sweep done: result=%h", result);
  endtask

  task automatic test_manual_sweep();
    do_reset();
    mode_auto = 1'b0;
    run_hold = 8;
    wait_ticks(20);
    vectors++;
    if (stim !== 3'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL manual_start: got stim=%0d busy=%b expected 0 1", stim, busy); end
    for (int k = 1; k < 8; k++) begin
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL manual_early_done: row %0d got done=%b expected 0", k, done); end
      step_hold = 8;
      wait_ticks(24);
      vectors++;
      if (int'(stim) !== k) begin miscompares++; $display("FAIL manual_step: got stim=%0d expected %0d", stim, k); end
      $display("manual press %0d: stim=%0d", k, stim);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL manual_done: got done=%b busy=%b expected 1 0", done, busy); end
    vectors++;
    if (result !== TABLE_EXP) begin miscompares++; $display("FAIL manual_result: got %h expected %h", result, TABLE_EXP); end
  endtask

  task automatic test_bounce();
    do_reset();
    mode_auto = 1'b0;
    run_hold = 8;
    wait_ticks(20);
    for (int i = 0; i < 12; i++) begin
      step_hold = (((i / 2) % 2) == 0) ? 1 : 0;
      tick();
    end
    step_hold = 10;
    wait_ticks(26);
    vectors++;
    if (stim !== 3'd1) begin miscompares++; $display("FAIL bounce_single_step: got stim=%0d expected 1", stim); end
    wait_ticks(20);
    vectors++;
    if (stim !== 3'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL bounce_no_extra: got stim=%0d busy=%b expected 1 1", stim, busy); end
    step_hold = 3;
    wait_ticks(24);
    vectors++;
    if (stim !== 3'd1) begin miscompares++; $display("FAIL glitch_ignored: got stim=%0d expected 1", stim); end
    $display("test_bounce done: stim=%0d", stim);
  endtask

  task automatic test_abort();
    bit found = 0;
    do_reset();
    mode_auto = 1'b1;
    run_hold = 8;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy && stim == 3'd5) begin found = 1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_reach_row5: got stim=%0d expected 5", stim); end
    run_hold = 8;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stim == 3'd0) begin found = 1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_restart: got stim=%0d expected 0", stim); end
    vectors++;
    if (result !== 16'h0 || busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_cleared: got result=%h busy=%b done=%b expected 0000 1 0", result, busy, done);
    end
    found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin found = 1; break; end
    end
    vectors++;
    if (!found || result !== TABLE_EXP) begin miscompares++; $display("FAIL abort_complete: got done=%b result=%h expected 1 %h", done, result, TABLE_EXP); end
    $display("test_abort done: result=%h", result);
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 0;
    do_reset();
    mode_auto = 1'b1;
    run_hold = 8;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy && stim == 3'd3) begin found = 1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL midreset_reach_row3: got stim=%0d expected 3", stim); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (stim !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_state: got stim=%0d busy=%b done=%b result=%h expected 0 0 0 0000", stim, busy, done, result);
    end
    mode_auto = 1'b0;
    step_hold = 8;
    wait_ticks(24);
    vectors++;
    if (stim !== 3'd0 || busy !== 1'b0 || result !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_step_ignored: got stim=%0d busy=%b result=%h expected 0 0 0000", stim, busy, result);
    end
    $display("test_reset_mid_sweep done");
  endtask

  task automatic test_mode_switch();
    bit got_done = 0;
    int prev;
    do_reset();
    mode_auto = 1'b0;
    run_hold = 8;
    wait_ticks(20);
    for (int k = 0; k < 2; k++) begin
      step_hold = 8;
      wait_ticks(24);
    end
    vectors++;
    if (stim !== 3'd2 || busy !== 1'b1) begin miscompares++; $display("FAIL mode_manual_row2: got stim=%0d busy=%b expected 2 1", stim, busy); end
    mode_auto = 1'b1;
    prev = int'(stim);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (int'(stim) != prev) begin
        vectors++;
        if (int'(stim) !== prev + 1) begin miscompares++; $display("FAIL mode_auto_order: got %0d expected %0d", stim, prev + 1); end
        prev = int'(stim);
      end
      if (done) begin got_done = 1; break; end
    end
    vectors++;
    if (!got_done || stim !== 3'd7) begin miscompares++; $display("FAIL mode_auto_finish: got done=%b stim=%0d expected 1 7", done, stim); end
    vectors++;
    if (result !== TABLE_EXP) begin miscompares++; $display("FAIL mode_result: got %h expected %h", result, TABLE_EXP); end
    step_hold = 8;
    wait_ticks(24);
    vectors++;
    if (stim !== 3'd7 || done !== 1'b1 || busy !== 1'b0 || result !== TABLE_EXP) begin
      miscompares++;
      $display("FAIL done_step_ignored: got stim=%0d done=%b busy=%b result=%h expected 7 1 0 %h", stim, done, busy, result, TABLE_EXP);
    end
    $display("test_mode_switch done: result=%h", result);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    run_hold    = 0;
    step_hold   = 0;
    reset       = 1'b1;
    btn_run     = 1'b0;
    btn_step    = 1'b0;
    mode_auto   = 1'b0;

    test_reset();
    test_auto_sweep();
    test_manual_sweep();
    test_bounce();
    test_abort();
    test_reset_mid_sweep();
    test_mode_switch();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
